// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with mid-bit sampling and framing-error strobe
module uart_rx #(
  parameter int CLK_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d;
  logic ferr_q, ferr_d;
  logic sync1_q, sync2_q, prev_q;
  logic rx_s;
  assign rx_s = sync2_q;
  assign rx_data = data_q;
  assign rx_valid = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy = state_q != IDLE;
  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end
  // Frame FSM: qualify start at half bit, then sample every full bit period
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = (prev_q && !rx_s) ? START : IDLE;
      end
      START: if (cnt_q == HALF_M1) begin
        cnt_d = '0;
        bit_idx_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        state_d = (bit_idx_q == 3'd7) ? STOP : DATA;
      end
      default: if (cnt_q == LAST) begin
        cnt_d = '0;
        state_d = IDLE;
        data_d = rx_s ? shift_q : data_q;
        valid_d = rx_s;
        ferr_d = !rx_s;
      end
    endcase
  end
  // State registers; reset abandons any frame in progress without a strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames with a byte scoreboard plus hand-written corner sequences
module tb_uart_rx;
  localparam int CPB = 16;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         pe;
    int         po;
    int         gap;
    logic [7:0] exp_data;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, rx_busy, rx_frame_err;
  int checks = 0;
  int passes = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int busy_cyc = 0;
  logic last_valid = 1'b0;
  logic last_ferr = 1'b0;
  logic [7:0] exp_q[$];
  vec_t vecs[7];
  int v0, f0, b0;

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_busy(rx_busy),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Serialise one frame; even-indexed bits last pe cycles, odd-indexed bits po cycles
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pe, input int po);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      repeat ((k % 2) ? po : pe) @(negedge clk);
    end
  endtask

  // Output monitor: pulse rules and scoreboard pop on every rx_valid
  always @(negedge clk) begin
    if (rx_busy) busy_cyc++;
    if (rx_valid || rx_frame_err) check("valid_ferr_exclusive", {31'd0, rx_valid & rx_frame_err}, 0);
    if (rx_valid) begin
      n_valid++;
      check("valid_width", {31'd0, last_valid}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected_valid: got data %0h with nothing expected", rx_data);
      end else check("sb_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
    if (rx_frame_err) begin
      n_ferr++;
      check("ferr_width", {31'd0, last_ferr}, 0);
    end
    last_valid = rx_valid;
    last_ferr = rx_frame_err;
  end

  initial begin
    vecs[0] = '{8'h55, 1'b1, 16, 16, 20, 8'h55};
    vecs[1] = '{8'hA3, 1'b1, 16, 16, 0, 8'hA3};
    vecs[2] = '{8'h00, 1'b1, 16, 16, 20, 8'h00};
    vecs[3] = '{8'h96, 1'b1, 17, 17, 20, 8'h96};
    vecs[4] = '{8'h96, 1'b1, 15, 17, 20, 8'h96};
    vecs[5] = '{8'h96, 1'b1, 17, 15, 20, 8'h96};
    vecs[6] = '{8'h3C, 1'b0, 16, 16, 0, 8'h96};
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 0);
    check("rst_valid", {31'd0, rx_valid}, 0);
    check("rst_busy", {31'd0, rx_busy}, 0);
    check("rst_ferr", {31'd0, rx_frame_err}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      v0 = n_valid;
      f0 = n_ferr;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].pe, vecs[i].po);
      check($sformatf("row%0d_valid", i), n_valid - v0, {31'd0, vecs[i].stop});
      check($sformatf("row%0d_ferr", i), n_ferr - f0, {31'd0, !vecs[i].stop});
      check($sformatf("row%0d_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
      if (vecs[i].gap > 0) begin
        rx = 1'b1;
        repeat (vecs[i].gap) @(negedge clk);
      end
    end
    b0 = busy_cyc;
    v0 = n_valid;
    f0 = n_ferr;
    repeat (40) @(negedge clk);
    check("break_busy", busy_cyc - b0, 0);
    check("break_strobes", (n_valid - v0) + (n_ferr - f0), 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    b0 = busy_cyc;
    v0 = n_valid;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_cycles", busy_cyc - b0, CPB / 2);
    check("glitch_idle", {31'd0, rx_busy}, 0);
    check("glitch_strobes", (n_valid - v0) + (n_ferr - f0), 0);
    check("glitch_data", {24'd0, rx_data}, 8'h96);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("mid_data_busy", {31'd0, rx_busy}, 1);
    rst = 1'b0;
    #1;
    check("async_rst_data", {24'd0, rx_data}, 0);
    check("async_rst_valid", {31'd0, rx_valid}, 0);
    check("async_rst_busy", {31'd0, rx_busy}, 0);
    check("async_rst_ferr", {31'd0, rx_frame_err}, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    v0 = n_valid;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, CPB, CPB);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_valid", n_valid - v0, 1);
    check("post_rst_data", {24'd0, rx_data}, 8'hC3);
    check("sb_drained", exp_q.size(), 0);
    check("total_valid", n_valid, 7);
    check("total_ferr", n_ferr, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
